// File: rtl/ad_ave.sv
// Two-channel ADC sample averager: accumulates a window of sample pairs and
// divides both sums by the window length with a shared-control restoring divider.
module ad_ave #(
    parameter int SW = 16,
    parameter int NW = 8
) (
    input  logic          clk_sys,
    input  logic          rst,
    input  logic [NW-1:0] cfg_ave,
    input  logic          ad_vld,
    input  logic [SW-1:0] ad_s1,
    input  logic [SW-1:0] ad_s2,
    output logic [SW-1:0] stu_data_s1,
    output logic [SW-1:0] stu_data_s2,
    output logic          ave_vld,
    output logic          ave_ovr
);

    localparam int ACC_W = SW + NW;
    localparam int IT_W  = $clog2(ACC_W);
    localparam logic [IT_W-1:0] IT_LAST = IT_W'(ACC_W - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DIV  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t          state_reg;
    logic [IT_W-1:0] it_reg;
    logic [NW-1:0]   cnt_reg;
    logic [NW-1:0]   n_lat_reg;
    logic [NW-1:0]   div_reg;
    logic            ave_vld_reg;
    logic            ave_ovr_reg;

    logic            cnt_zero;
    logic [NW-1:0]   n_eff;
    logic            win_close;
    logic            div_load;
    logic            div_step;
    logic            win_drop;

    // The window length comes from cfg_ave only on the first sample of a window.
    assign cnt_zero  = (cnt_reg == '0);
    assign n_eff     = cnt_zero ? ((cfg_ave == '0) ? NW'(1) : cfg_ave) : n_lat_reg;
    assign win_close = ad_vld && (({1'b0, cnt_reg} + 1'b1) == {1'b0, n_eff});
    assign div_load  = win_close && (state_reg == ST_IDLE || state_reg == ST_DONE);
    assign div_step  = (state_reg == ST_DIV);
    assign win_drop  = win_close && (state_reg == ST_DIV);

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            it_reg      <= '0;
            cnt_reg     <= '0;
            n_lat_reg   <= '0;
            div_reg     <= '0;
            ave_vld_reg <= 1'b0;
            ave_ovr_reg <= 1'b0;
        end else begin
            ave_vld_reg <= 1'b0;
            ave_ovr_reg <= win_drop;
            if (ad_vld) begin
                if (cnt_zero) begin
                    n_lat_reg <= n_eff;
                end
                cnt_reg <= win_close ? '0 : cnt_reg + 1'b1;
            end
            case (state_reg)
                ST_IDLE: begin
                    if (win_close) begin
                        state_reg <= ST_DIV;
                        it_reg    <= '0;
                        div_reg   <= n_eff;
                    end
                end
                ST_DIV: begin
                    if (it_reg == IT_LAST) begin
                        state_reg <= ST_DONE;
                    end else begin
                        it_reg <= it_reg + 1'b1;
                    end
                end
                ST_DONE: begin
                    ave_vld_reg <= 1'b1;
                    if (win_close) begin
                        state_reg <= ST_DIV;
                        it_reg    <= '0;
                        div_reg   <= n_eff;
                    end else begin
                        state_reg <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    // Per-channel datapath: accumulator, restoring divider and status word.
    for (genvar gi = 0; gi < 2; gi++) begin : g_ch
        logic [SW-1:0]    samp;
        logic [ACC_W-1:0] acc_reg;
        logic [ACC_W-1:0] acc_next;
        logic [ACC_W-1:0] quo_reg;
        logic [NW-1:0]    rem_reg;
        logic [NW:0]      trial;
        logic             qbit;
        logic [NW-1:0]    rem_next;
        logic [SW-1:0]    stu_reg;

        assign samp     = (gi == 0) ? ad_s1 : ad_s2;
        assign acc_next = cnt_zero ? {{NW{1'b0}}, samp} : acc_reg + {{NW{1'b0}}, samp};

        // Remainder stays below the divisor, so one extra bit holds the trial value.
        assign trial    = {rem_reg, quo_reg[ACC_W-1]};
        assign qbit     = (trial >= {1'b0, div_reg});
        assign rem_next = qbit ? NW'(trial - {1'b0, div_reg}) : trial[NW-1:0];

        always_ff @(posedge clk_sys) begin
            if (rst) begin
                acc_reg <= '0;
                quo_reg <= '0;
                rem_reg <= '0;
                stu_reg <= '0;
            end else begin
                if (ad_vld) begin
                    acc_reg <= acc_next;
                end
                if (div_load) begin
                    quo_reg <= acc_next;
                    rem_reg <= '0;
                end else if (div_step) begin
                    quo_reg <= {quo_reg[ACC_W-2:0], qbit};
                    rem_reg <= rem_next;
                end
                if (state_reg == ST_DONE) begin
                    stu_reg <= quo_reg[SW-1:0];
                end
            end
        end
    end

    assign stu_data_s1 = g_ch[0].stu_reg;
    assign stu_data_s2 = g_ch[1].stu_reg;
    assign ave_vld     = ave_vld_reg;
    assign ave_ovr     = ave_ovr_reg;

endmodule

// File: tb/tb_ad_ave.sv
// Scoreboard bench for ad_ave: expected averages and arrival cycles are queued
// when the closing sample is driven and checked when ave_vld pulses.
module tb_ad_ave;

    logic        clk_sys = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  cfg_ave = 8'd1;
    logic        ad_vld = 1'b0;
    logic [15:0] ad_s1 = '0;
    logic [15:0] ad_s2 = '0;
    logic [15:0] stu_data_s1;
    logic [15:0] stu_data_s2;
    logic        ave_vld;
    logic        ave_ovr;

    typedef struct {
        logic [15:0] s1;
        logic [15:0] s2;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   ovr_cnt = 0;
    int   vld_cnt = 0;

    ad_ave #(.SW(16), .NW(8)) dut (
        .clk_sys     (clk_sys),
        .rst         (rst),
        .cfg_ave     (cfg_ave),
        .ad_vld      (ad_vld),
        .ad_s1       (ad_s1),
        .ad_s2       (ad_s2),
        .stu_data_s1 (stu_data_s1),
        .stu_data_s2 (stu_data_s2),
        .ave_vld     (ave_vld),
        .ave_ovr     (ave_ovr)
    );

    always #5 clk_sys = ~clk_sys;

    always @(posedge clk_sys) cyc <= cyc + 1;

    always @(negedge clk_sys) begin : monitor
        exp_t e;
        if (!rst) begin
            if (ave_ovr) ovr_cnt++;
            if (ave_vld) begin
                vld_cnt++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_vld cyc=%0d s1=%h s2=%h", cyc, stu_data_s1, stu_data_s2);
                end else begin
                    e = exp_q.pop_front();
                    if (stu_data_s1 !== e.s1 || stu_data_s2 !== e.s2 || cyc != e.cyc) begin
                        errors++;
                        $display("FAIL result got s1=%h s2=%h cyc=%0d want s1=%h s2=%h cyc=%0d",
                                 stu_data_s1, stu_data_s2, cyc, e.s1, e.s2, e.cyc);
                    end else begin
                        $display("txn ok s1=%h s2=%h cyc=%0d", stu_data_s1, stu_data_s2, cyc);
                    end
                end
            end
        end
    end

    task automatic send(input logic [15:0] a, input logic [15:0] b, output int acc_cyc);
        @(negedge clk_sys);
        ad_vld  = 1'b1;
        ad_s1   = a;
        ad_s2   = b;
        acc_cyc = cyc + 1;
        @(negedge clk_sys);
        ad_vld = 1'b0;
    endtask

    task automatic push(input logic [15:0] a, input logic [15:0] b, input int c);
        exp_t e;
        e.s1 = a;
        e.s2 = b;
        e.cyc = c;
        exp_q.push_back(e);
    endtask

    task automatic wait_drain(input int budget, input int exp_vld, input int exp_ovr, input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk_sys);
            n++;
        end
        repeat (5) @(negedge clk_sys);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_timeout pending=%0d want 0", name, exp_q.size());
            exp_q.delete();
        end
        checks++;
        if (vld_cnt != exp_vld) begin
            errors++;
            $display("FAIL %s_vld_count got %0d want %0d", name, vld_cnt, exp_vld);
        end
        checks++;
        if (ovr_cnt != exp_ovr) begin
            errors++;
            $display("FAIL %s_ovr_count got %0d want %0d", name, ovr_cnt, exp_ovr);
        end
        vld_cnt = 0;
        ovr_cnt = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_sys);
            ad_vld = ~ad_vld;
            ad_s1  = 16'($urandom);
            ad_s2  = 16'($urandom);
            checks++;
            if (stu_data_s1 !== 16'h0 || stu_data_s2 !== 16'h0 || ave_vld !== 1'b0 || ave_ovr !== 1'b0) begin
                errors++;
                $display("FAIL reset_outputs got s1=%h s2=%h vld=%b ovr=%b want all 0",
                         stu_data_s1, stu_data_s2, ave_vld, ave_ovr);
            end
        end
        @(negedge clk_sys);
        rst    = 1'b0;
        ad_vld = 1'b0;
        vld_cnt = 0;
        ovr_cnt = 0;
    endtask

    task automatic test_n4();
        int c;
        int sum1 = 0;
        for (int i = 1; i <= 4; i++) begin
            send(16'(i * 100), 16'hFFFF, c);
            sum1 += i * 100;
        end
        push(16'(sum1 / 4), 16'hFFFF, c + 25);
        wait_drain(100, 1, 0, "n4");
    endtask

    task automatic test_truncation();
        int c;
        cfg_ave = 8'd3;
        send(16'd1, 16'd5, c);
        send(16'd1, 16'd5, c);
        send(16'd2, 16'd6, c);
        push(16'((1 + 1 + 2) / 3), 16'((5 + 5 + 6) / 3), c + 25);
        wait_drain(100, 1, 0, "trunc");
        cfg_ave = 8'd0;
        send(16'h1234, 16'hABCD, c);
        push(16'h1234, 16'hABCD, c + 25);
        wait_drain(100, 1, 0, "n0");
    endtask

    task automatic test_max_window();
        int c;
        int sum2 = 0;
        cfg_ave = 8'd255;
        for (int i = 0; i < 255; i++) begin
            send(16'hFFFF, 16'(i * 257), c);
            sum2 += i * 257;
        end
        push(16'hFFFF, 16'(sum2 / 255), c + 25);
        wait_drain(100, 1, 0, "max");
    endtask

    task automatic test_overrun();
        cfg_ave = 8'd1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk_sys);
            ad_vld = 1'b1;
            ad_s1  = 16'(i + 1);
            ad_s2  = 16'(1000 + i);
            if (i % 25 == 0) push(16'(i + 1), 16'(1000 + i), cyc + 1 + 25);
        end
        @(negedge clk_sys);
        ad_vld = 1'b0;
        wait_drain(100, 3, 57, "overrun");
    endtask

    task automatic test_cfg_change();
        int c;
        cfg_ave = 8'd4;
        send(16'd10, 16'd1, c);
        send(16'd20, 16'd2, c);
        cfg_ave = 8'd2;
        send(16'd30, 16'd3, c);
        send(16'd40, 16'd4, c);
        push(16'((10 + 20 + 30 + 40) / 4), 16'((1 + 2 + 3 + 4) / 4), c + 25);
        wait_drain(100, 1, 0, "cfg4");
        send(16'd7, 16'd100, c);
        send(16'd8, 16'd101, c);
        push(16'((7 + 8) / 2), 16'((100 + 101) / 2), c + 25);
        wait_drain(100, 1, 0, "cfg2");
    endtask

    task automatic test_reset_mid_div();
        int c;
        cfg_ave = 8'd1;
        send(16'h5555, 16'h6666, c);
        while (cyc < c + 10) @(negedge clk_sys);
        rst = 1'b1;
        @(negedge clk_sys);
        checks++;
        if (stu_data_s1 !== 16'h0 || stu_data_s2 !== 16'h0 || ave_vld !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_outputs got s1=%h s2=%h vld=%b want 0", stu_data_s1, stu_data_s2, ave_vld);
        end
        rst = 1'b0;
        repeat (40) @(negedge clk_sys);
        checks++;
        if (stu_data_s1 !== 16'h0 || stu_data_s2 !== 16'h0) begin
            errors++;
            $display("FAIL rst_mid_hold got s1=%h s2=%h want 0", stu_data_s1, stu_data_s2);
        end
        wait_drain(10, 0, 0, "rst_mid");
        send(16'h0102, 16'h0304, c);
        push(16'h0102, 16'h0304, c + 25);
        wait_drain(100, 1, 0, "after_rst");
    endtask

    initial begin
        test_reset();
        cfg_ave = 8'd4;
        test_n4();
        test_truncation();
        test_max_window();
        test_overrun();
        test_cfg_change();
        test_reset_mid_div();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
